// File: rtl/mult_arbiter.sv
// ---------------------------------------------------------------------------
// mult_arbiter
//
// Shares a single in-order multiplier between two requesters. Operand pairs
// are accepted one at a time, held in local registers while the multiplier's
// independent a/b input channels take them, and the issuing requester is
// recorded in a small tag FIFO. Products are steered back to the requester
// whose tag is at the FIFO head.
//
// Build option:
//   MULT_ARB_FIXED_PRIO_EN  defined   -> requester 0 always wins a tie
//                           undefined -> round-robin between the requesters
//
// Parameters:
//   SIZE   product width; operands are SIZE/2 bits
//   DEPTH  maximum outstanding multiplications (power of two, >= 2)
//
// Ports:
//   clk, rst                         clock, synchronous active-low reset
//   req{0,1}_a_tdata/_b_tdata        operand pair from requester 0/1
//   req{0,1}_tvalid / _tready        operand-pair handshake
//   resp{0,1}_tdata/_tvalid/_tready  product returned to requester 0/1
//   mult_a_*/mult_b_*                operand channels toward the multiplier
//   mult_out_*                       product channel from the multiplier
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module mult_arbiter #(
  parameter int SIZE  = 32,
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,

  input  logic [SIZE/2-1:0]   req0_a_tdata,
  input  logic [SIZE/2-1:0]   req0_b_tdata,
  input  logic                req0_tvalid,
  output logic                req0_tready,
  output logic [SIZE-1:0]     resp0_tdata,
  output logic                resp0_tvalid,
  input  logic                resp0_tready,

  input  logic [SIZE/2-1:0]   req1_a_tdata,
  input  logic [SIZE/2-1:0]   req1_b_tdata,
  input  logic                req1_tvalid,
  output logic                req1_tready,
  output logic [SIZE-1:0]     resp1_tdata,
  output logic                resp1_tvalid,
  input  logic                resp1_tready,

  output logic [SIZE/2-1:0]   mult_a_tdata,
  output logic                mult_a_tvalid,
  input  logic                mult_a_tready,
  output logic [SIZE/2-1:0]   mult_b_tdata,
  output logic                mult_b_tvalid,
  input  logic                mult_b_tready,

  input  logic [SIZE-1:0]     mult_out_tdata,
  input  logic                mult_out_tvalid,
  output logic                mult_out_tready
);

  localparam int HALF  = SIZE / 2;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  // Operand holding registers and issue bookkeeping
  logic [HALF-1:0]   r_a_op;
  logic [HALF-1:0]   r_b_op;
  logic              r_owner;
  logic              r_a_done;
  logic              r_b_done;
`ifndef MULT_ARB_FIXED_PRIO_EN
  logic              r_last;
`endif

  // Tag FIFO
  logic              r_tag [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic              w_full;
  logic              w_empty;
  logic              w_head;
  logic              w_grant0;
  logic              w_grant1;
  logic              w_a_fire;
  logic              w_b_fire;
  logic              w_push;
  logic              w_pop;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_head  = r_tag[r_rd_ptr];

  // -------------------------------------------------------------------------
  // FSM: next state, grants and multiplier input valids
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    w_grant0      = 1'b0;
    w_grant1      = 1'b0;
    mult_a_tvalid = 1'b0;
    mult_b_tvalid = 1'b0;
    w_a_fire      = 1'b0;
    w_b_fire      = 1'b0;
    w_push        = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // A grant is only offered while there is room for its tag, so a
        // push can never land on a full FIFO.
        if (!w_full) begin
`ifdef MULT_ARB_FIXED_PRIO_EN
          w_grant0 = req0_tvalid;
          w_grant1 = req1_tvalid & ~req0_tvalid;
`else
          if (req0_tvalid && req1_tvalid) begin
            // Tie goes to whoever did not win last time.
            w_grant0 = r_last;
            w_grant1 = ~r_last;
          end else begin
            w_grant0 = req0_tvalid;
            w_grant1 = req1_tvalid;
          end
`endif
        end
        if (w_grant0 || w_grant1) begin
          w_state_nxt = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        mult_a_tvalid = ~r_a_done;
        mult_b_tvalid = ~r_b_done;
        w_a_fire      = ~r_a_done & mult_a_tready;
        w_b_fire      = ~r_b_done & mult_b_tready;
        // Both channels may complete in the same cycle or in any order.
        if ((r_a_done || w_a_fire) && (r_b_done || w_b_fire)) begin
          w_push      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Grants are only raised for a valid requester, so grant == handshake.
  assign req0_tready  = w_grant0;
  assign req1_tready  = w_grant1;

  assign mult_a_tdata = r_a_op;
  assign mult_b_tdata = r_b_op;

  // -------------------------------------------------------------------------
  // FSM state and operand registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_a_op   <= '0;
      r_b_op   <= '0;
      r_owner  <= 1'b0;
      r_a_done <= 1'b0;
      r_b_done <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant0 || w_grant1) begin
        r_a_op   <= w_grant1 ? req1_a_tdata : req0_a_tdata;
        r_b_op   <= w_grant1 ? req1_b_tdata : req0_b_tdata;
        r_owner  <= w_grant1;
        r_a_done <= 1'b0;
        r_b_done <= 1'b0;
      end else begin
        if (w_a_fire) begin
          r_a_done <= 1'b1;
        end
        if (w_b_fire) begin
          r_b_done <= 1'b1;
        end
      end
    end
  end

`ifndef MULT_ARB_FIXED_PRIO_EN
  // Starts at 1 so requester 0 takes the first tie after reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_last <= 1'b1;
    end else if (w_grant0 || w_grant1) begin
      r_last <= w_grant1;
    end
  end
`endif

  // -------------------------------------------------------------------------
  // Tag FIFO: issue order of outstanding multiplications
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Tag storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_tag[r_wr_ptr] <= r_owner;
    end
  end

  // -------------------------------------------------------------------------
  // Response routing: purely combinational from the FIFO head
  // -------------------------------------------------------------------------
  // With nothing outstanding, the product channel is neither accepted nor
  // forwarded, so a stray product is never consumed.
  assign resp0_tvalid    = mult_out_tvalid & ~w_empty & ~w_head;
  assign resp1_tvalid    = mult_out_tvalid & ~w_empty &  w_head;
  assign resp0_tdata     = (~w_empty & ~w_head) ? mult_out_tdata : '0;
  assign resp1_tdata     = (~w_empty &  w_head) ? mult_out_tdata : '0;
  assign mult_out_tready = ~w_empty & (w_head ? resp1_tready : resp0_tready);
  assign w_pop           = mult_out_tvalid & mult_out_tready;

endmodule

`default_nettype wire

// File: tb/tb_mult_arbiter.sv
`timescale 1ns/1ps

module tb_mult_arbiter;
  localparam int SIZE  = 32;
  localparam int DEPTH = 4;
  localparam int H     = SIZE / 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [H-1:0]    req0_a_tdata, req0_b_tdata, req1_a_tdata, req1_b_tdata;
  logic            req0_tvalid, req0_tready, req1_tvalid, req1_tready;
  logic [SIZE-1:0] resp0_tdata, resp1_tdata;
  logic            resp0_tvalid, resp0_tready, resp1_tvalid, resp1_tready;
  logic [H-1:0]    mult_a_tdata, mult_b_tdata;
  logic            mult_a_tvalid, mult_a_tready, mult_b_tvalid, mult_b_tready;
  logic [SIZE-1:0] mult_out_tdata;
  logic            mult_out_tvalid, mult_out_tready;

  always #5 clk = ~clk;

  mult_arbiter #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req0_a_tdata(req0_a_tdata), .req0_b_tdata(req0_b_tdata),
    .req0_tvalid(req0_tvalid), .req0_tready(req0_tready),
    .resp0_tdata(resp0_tdata), .resp0_tvalid(resp0_tvalid), .resp0_tready(resp0_tready),
    .req1_a_tdata(req1_a_tdata), .req1_b_tdata(req1_b_tdata),
    .req1_tvalid(req1_tvalid), .req1_tready(req1_tready),
    .resp1_tdata(resp1_tdata), .resp1_tvalid(resp1_tvalid), .resp1_tready(resp1_tready),
    .mult_a_tdata(mult_a_tdata), .mult_a_tvalid(mult_a_tvalid), .mult_a_tready(mult_a_tready),
    .mult_b_tdata(mult_b_tdata), .mult_b_tvalid(mult_b_tvalid), .mult_b_tready(mult_b_tready),
    .mult_out_tdata(mult_out_tdata), .mult_out_tvalid(mult_out_tvalid),
    .mult_out_tready(mult_out_tready)
  );

  typedef struct { logic [H-1:0] a; logic [H-1:0] b; } op_t;
  typedef struct { int id; logic [SIZE-1:0] p; } exp_t;

  op_t             q0[$];
  op_t             q1[$];
  exp_t            exp_q[$];
  logic [SIZE-1:0] mq[$];
  int              md[$];
  logic [SIZE-1:0] r0_log[$];
  logic [SIZE-1:0] r1_log[$];
  int              grant_log[$];

  logic            pa_v = 1'b0, pb_v = 1'b0;
  logic [H-1:0]    pa, pb;
  int              a_sends = 0, b_sends = 0;
  bit              rnd = 1'b0;
  bit              r1_seen = 1'b0;
  logic            a_rdy = 1'b1, b_rdy = 1'b1, r0_rdy = 1'b1, r1_rdy = 1'b1;
  int              checks = 0;
  int              failures = 0;

  function automatic logic [SIZE-1:0] mulp(logic [H-1:0] a, logic [H-1:0] b);
    return SIZE'(a) * SIZE'(b);
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [SIZE-1:0] at0(int i);
    return (i < r0_log.size()) ? r0_log[i] : '1;
  endfunction
  function automatic logic [SIZE-1:0] at1(int i);
    return (i < r1_log.size()) ? r1_log[i] : '1;
  endfunction

  // Drive all bench-owned inputs for the current cycle (called at negedge).
  task automatic apply();
    req0_tvalid  = (q0.size() > 0);
    req0_a_tdata = req0_tvalid ? q0[0].a : '0;
    req0_b_tdata = req0_tvalid ? q0[0].b : '0;
    req1_tvalid  = (q1.size() > 0);
    req1_a_tdata = req1_tvalid ? q1[0].a : '0;
    req1_b_tdata = req1_tvalid ? q1[0].b : '0;
    if (rnd) begin
      mult_a_tready = 1'($urandom_range(0, 1));
      mult_b_tready = 1'($urandom_range(0, 1));
      resp0_tready  = 1'($urandom_range(0, 1));
      resp1_tready  = 1'($urandom_range(0, 1));
    end else begin
      mult_a_tready = a_rdy;
      mult_b_tready = b_rdy;
      resp0_tready  = r0_rdy;
      resp1_tready  = r1_rdy;
    end
    mult_out_tvalid = 1'b0;
    mult_out_tdata  = '0;
    if (mq.size() > 0) begin
      if (md[0] == 0) begin
        mult_out_tvalid = 1'b1;
        mult_out_tdata  = mq[0];
      end
    end
  endtask

  // Observe the handshakes about to complete on the coming edge.
  task automatic sample();
    exp_t e;
    if (rst == 1'b0) begin
      mq.delete(); md.delete(); pa_v = 1'b0; pb_v = 1'b0;
      return;
    end
    if (resp1_tvalid) r1_seen = 1'b1;
    if (req0_tvalid && req0_tready) begin
      e.id = 0; e.p = mulp(q0[0].a, q0[0].b);
      exp_q.push_back(e); void'(q0.pop_front()); grant_log.push_back(0);
    end
    if (req1_tvalid && req1_tready) begin
      e.id = 1; e.p = mulp(q1[0].a, q1[0].b);
      exp_q.push_back(e); void'(q1.pop_front()); grant_log.push_back(1);
    end
    if (mult_out_tvalid && mult_out_tready) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        failures++;
        $error("FAIL sb_stray observed_product=%0d expected=no_product", mult_out_tdata);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.id == 0) begin
          check("sb_r0_valid", resp0_tvalid, 1);
          check("sb_r1_quiet", resp1_tvalid, 0);
          check("sb_r0_data", resp0_tdata, e.p);
          r0_log.push_back(resp0_tdata);
        end else begin
          check("sb_r1_valid", resp1_tvalid, 1);
          check("sb_r0_quiet", resp0_tvalid, 0);
          check("sb_r1_data", resp1_tdata, e.p);
          r1_log.push_back(resp1_tdata);
        end
      end
      void'(mq.pop_front()); void'(md.pop_front());
    end
    foreach (md[i]) if (md[i] > 0) md[i]--;
    if (mult_a_tvalid && mult_a_tready) begin pa_v = 1'b1; pa = mult_a_tdata; a_sends++; end
    if (mult_b_tvalid && mult_b_tready) begin pb_v = 1'b1; pb = mult_b_tdata; b_sends++; end
    if (pa_v && pb_v) begin
      mq.push_back(mulp(pa, pb));
      md.push_back(rnd ? $urandom_range(0, 3) : 0);
      pa_v = 1'b0; pb_v = 1'b0;
    end
  endtask

  task automatic pre();
    apply();
    #4;
  endtask

  task automatic post();
    sample();
    @(negedge clk);
  endtask

  task automatic clear_sb();
    q0.delete(); q1.delete(); exp_q.delete();
    r0_log.delete(); r1_log.delete(); grant_log.delete();
    r1_seen = 1'b0;
  endtask

  task automatic do_reset(int n);
    rst = 1'b0;
    clear_sb();
    repeat (n) begin pre(); post(); end
    rst = 1'b1;
  endtask

  task automatic wait_resps(string tag, int n, int budget);
    int c = 0;
    while ((r0_log.size() + r1_log.size()) < n && c < budget) begin
      pre(); post(); c++;
    end
    check(tag, r0_log.size() + r1_log.size(), n);
  endtask

  task automatic wait_grants(string tag, int n, int budget);
    int c = 0;
    while (grant_log.size() < n && c < budget) begin
      pre(); post(); c++;
    end
    check(tag, grant_log.size(), n);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int c;
    req0_tvalid = 0; req1_tvalid = 0; mult_out_tvalid = 0;
    @(negedge clk);

    // Reset state
    rst = 1'b0;
    pre(); post();
    pre();
    check("rst_req0_tready", req0_tready, 0);
    check("rst_req1_tready", req1_tready, 0);
    check("rst_mult_a_tvalid", mult_a_tvalid, 0);
    check("rst_mult_b_tvalid", mult_b_tvalid, 0);
    check("rst_mult_a_tdata", mult_a_tdata, 0);
    check("rst_mult_b_tdata", mult_b_tdata, 0);
    check("rst_resp0_tvalid", resp0_tvalid, 0);
    check("rst_resp1_tvalid", resp1_tvalid, 0);
    check("rst_resp0_tdata", resp0_tdata, 0);
    check("rst_mult_out_tready", mult_out_tready, 0);
    post();
    rst = 1'b1;

    // Single request
    q0.push_back('{16'd1332, 16'd544});
    wait_resps("t1_done", 1, 30);
    check("t1_prod", at0(0), 724608);
    check("t1_r1_quiet", r1_seen, 0);
    pre(); check("t1_fifo_empty", mult_out_tready, 0); post();

    // Tie straight after reset
    do_reset(1);
    q0.push_back('{16'd3, 16'd5});
    q1.push_back('{16'd7, 16'd11});
    pre();
    check("t2_tie_req0", req0_tready, 1);
    check("t2_tie_req1", req1_tready, 0);
    post();
    wait_resps("t2_done", 2, 40);
    check("t2_grant_first", (grant_log.size() > 0) ? grant_log[0] : -1, 0);
    check("t2_grant_second", (grant_log.size() > 1) ? grant_log[1] : -1, 1);
    check("t2_resp0", at0(0), 15);
    check("t2_resp1", at1(0), 77);

`ifdef MULT_ARB_FIXED_PRIO_EN
    // Held req0 starves req1
    clear_sb();
    for (int i = 1; i <= 5; i++) q0.push_back('{16'(i), 16'd2});
    q1.push_back('{16'd9, 16'd9});
    wait_grants("t2f_grants", 6, 60);
    check("t2f_req1_last", (grant_log.size() > 5) ? grant_log[5] : -1, 1);
    wait_resps("t2f_done", 6, 60);
`endif

    // Split ready on the multiplier inputs
    do_reset(1);
    a_rdy = 1'b0; b_rdy = 1'b0; a_sends = 0; b_sends = 0;
    q0.push_back('{16'd5, 16'd6});
    pre(); check("t3_grant", req0_tready, 1); post();
    a_rdy = 1'b1;
    pre();
    check("t3_n_a_valid", mult_a_tvalid, 1);
    check("t3_n_b_valid", mult_b_tvalid, 1);
    check("t3_n_a_data", mult_a_tdata, 5);
    post();
    a_rdy = 1'b0;
    pre();
    check("t3_n1_a_valid", mult_a_tvalid, 0);
    check("t3_n1_b_valid", mult_b_tvalid, 1);
    post();
    pre(); post();
    b_rdy = 1'b1;
    q1.push_back('{16'd2, 16'd9});
    pre();
    check("t3_n3_no_grant", req1_tready, 0);
    check("t3_n3_b_valid", mult_b_tvalid, 1);
    post();
    pre();
    check("t3_n4_idle_grant", req1_tready, 1);
    check("t3_a_sends", a_sends, 1);
    check("t3_b_sends", b_sends, 1);
    post();
    a_rdy = 1'b1;
    wait_resps("t3_done", 2, 40);
    check("t3_resp0", at0(0), 30);
    check("t3_resp1", at1(0), 18);
    pre(); check("t3_fifo_empty", mult_out_tready, 0); post();

    // Full FIFO under response backpressure
    do_reset(1);
    r0_rdy = 1'b0;
    for (int i = 1; i <= 4; i++) q0.push_back('{16'(i), 16'd10});
    wait_grants("t4_fill", 4, 40);
    q0.push_back('{16'd5, 16'd10});
    q1.push_back('{16'd6, 16'd10});
    repeat (3) begin
      pre();
      check("t4_full_req0", req0_tready, 0);
      check("t4_full_req1", req1_tready, 0);
      post();
    end
    r0_rdy = 1'b1;
    pre();
    check("t4_pop_cycle_req0", req0_tready, 0);
    check("t4_pop_cycle_req1", req1_tready, 0);
    check("t4_pop_ready", mult_out_tready, 1);
    post();
    r0_rdy = 1'b0;
    pre();
    check("t4_regrant_req1", req1_tready, 1);
    check("t4_regrant_req0", req0_tready, 0);
    post();
    r0_rdy = 1'b1;
    wait_resps("t4_drain", 6, 80);
    check("t4_r0_count", r0_log.size(), 5);
    check("t4_r0_last", at0(4), 50);
    check("t4_r1", at1(0), 60);

    // Interleaved requests, random-latency multiplier
    do_reset(1);
    rnd = 1'b1;
    q0.push_back('{16'd2, 16'd2}); q0.push_back('{16'd4, 16'd4});
    q1.push_back('{16'd3, 16'd3}); q1.push_back('{16'd5, 16'd5});
    wait_resps("t5_done", 4, 400);
    rnd = 1'b0;
    check("t5_r0_first", at0(0), 4);
    check("t5_r0_second", at0(1), 16);
    check("t5_r1_first", at1(0), 9);
    check("t5_r1_second", at1(1), 25);

    // Reset while b is still pending
    do_reset(1);
    a_rdy = 1'b1; b_rdy = 1'b0;
    q0.push_back('{16'd9, 16'd9});
    seen = 1'b0; c = 0;
    while (!seen && c < 10) begin
      pre(); if (mult_b_tvalid) seen = 1'b1; post(); c++;
    end
    check("t6_issue_reached", seen, 1);
    rst = 1'b0;
    clear_sb();
    pre(); check("t6_b_valid_at_reset", mult_b_tvalid, 1); post();
    rst = 1'b1;
    r0_rdy = 1'b1; r1_rdy = 1'b1;
    pre();
    check("t6_a_valid", mult_a_tvalid, 0);
    check("t6_b_valid", mult_b_tvalid, 0);
    check("t6_b_data", mult_b_tdata, 0);
    check("t6_resp_valids", {resp0_tvalid, resp1_tvalid}, 0);
    check("t6_fifo_empty", mult_out_tready, 0);
    post();
    b_rdy = 1'b1;
    q1.push_back('{16'd6, 16'd7});
    wait_resps("t6_done", 1, 30);
    check("t6_resp1", at1(0), 42);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Round-robin arbiter that shares one `karatsuba_mult` instance between two requesters in the ElGamal datapath (e.g. the key-stream and ciphertext stages). Accepts operand pairs from either requester, sequences them into the multiplier's AXI-stream-style a/b inputs, and tracks issue order with a tag FIFO. Each product is routed back to the requester that issued it.

## Interface
Parameters:
- `SIZE`, 32, product width; operands are `SIZE/2` bits.
- `DEPTH`, 4, maximum outstanding multiplications; tag FIFO depth, power of two, ≥2.

Ports:
- `clk`  in  1  single clock; everything on rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `req0_a_tdata`, `req0_b_tdata`  in  SIZE/2  requester 0 operands.
- `req0_tvalid`  in  1  / `req0_tready`  out  1  requester 0 operand-pair handshake.
- `resp0_tdata`  out  SIZE  / `resp0_tvalid`  out  1  / `resp0_tready`  in  1  requester 0 product.
- `req1_*`, `resp1_*`  same widths and meaning as the requester 0 ports, for requester 1.
- `mult_a_tdata`, `mult_b_tdata`  out  SIZE/2  operands to the multiplier.
- `mult_a_tvalid`, `mult_b_tvalid`  out  1  / `mult_a_tready`, `mult_b_tready`  in  1  multiplier input handshakes.
- `mult_out_tdata`  in  SIZE  / `mult_out_tvalid`  in  1  / `mult_out_tready`  out  1  multiplier product.

## Operation
- FSM states:
  - IDLE: accept a request.
  - ISSUE: drive the latched operands to the multiplier.
- **IDLE:**
  - If FIFO not full and any `reqN_tvalid`, choose winner W.
  - Assert `reqW_tready` combinationally.
  - On that handshake, latch operands, set `owner`=W, clear `a_done`/`b_done`, go to ISSUE.
- **Arbitration:**
  - `last` register holds the previous winner.
  - If both requesters are valid, grant the one ≠ `last`; otherwise grant the valid one.
  - `last` updates on grant.
- **ISSUE:**
  - `mult_a_tvalid` = !`a_done`; `mult_b_tvalid` = !`b_done`; data comes from the latched registers.
  - Set `a_done`/`b_done` on the respective handshake.
  - When both sides are accepted (same or different cycles), push `owner` into the tag FIFO and return to IDLE.
- **Response routing:**
  - Head tag H selects the destination.
  - `respH_tvalid` = `mult_out_tvalid` & !empty; `respH_tdata` = `mult_out_tdata`.
  - `mult_out_tready` = `respH_tready` & !empty.
  - The non-selected resp valid is 0.
  - Pop on the `mult_out` handshake.
- **Empty FIFO:** `mult_out_tready`=0 and both resp valids = 0, so a stray product is never consumed.
- **Simultaneous push and pop:** count unchanged; both pointers advance.
- **Full FIFO (DEPTH outstanding):** no grant in IDLE; both `reqN_tready`=0 until a pop.
- **Ordering:** products return in issue order. The multiplier must be in-order.

## Timing
- Reset values:
  - Outputs: all `tready`/`tvalid` outputs 0; all tdata outputs 0.
  - State: FSM=IDLE, FIFO empty, `last`=1 (req0 wins first tie).
- `reqN_tready` is combinational from state, valids, `last` and the full flag; it is never high outside IDLE.
- Request accepted in cycle N → `mult_a_tvalid`/`mult_b_tvalid` high from N+1.
- Minimum issue interval is 2 cycles (IDLE+ISSUE).
- Response path adds zero cycles; routing is combinational from the FIFO head.
- Reset mid-operation: FSM, latched operands and FIFO clear next edge. The multiplier must share `rst` so that no orphaned products remain.

## Configuration
- `MULT_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority, req0 always beats req1; `last` is unused.
  - Undefined (default): round-robin as above.
- FIFO, routing and FSM are identical in both builds.

## Test plan
- Single request: req0 a=1332, b=544, multiplier model always ready → product 724608 on `resp0_tdata`, `resp1_tvalid` stays 0, FIFO empty afterwards.
- Tie: req0 (3×5) and req1 (7×11) valid together after reset → req0 granted first, req1 granted next; resp0=15, then resp1=77. With `MULT_ARB_FIXED_PRIO_EN` and req0 held valid, req1 starves.
- Split ready: `mult_a_tready` high in cycle N, `mult_b_tready` only at N+3 → a sent once, b sent once, a single FIFO push, return to IDLE at N+4.
- Backpressure/full: DEPTH=4, `mult_out_tready` path blocked by `resp0_tready`=0 for 4 issued req0 ops → 5th request sees `req*_tready`=0; releasing one response re-enables the grant the same cycle the pop is visible.
- Interleave order: alternating req0/req1 ops 2×2, 3×3, 4×4, 5×5 with a random-latency in-order multiplier model → resp0 gets 4, 16 and resp1 gets 9, 25, in order.
- Reset mid-ISSUE: `rst`=0 for one cycle while `mult_b_tvalid`=1 → next cycle all valids 0, FSM IDLE, FIFO empty; a new request then completes normally.
